// File: rtl/serial_chunk_sub.sv
// Chunk-serial subtractor: d = a - b - bin over WIDTH bits, CHUNK bits per clock, with borrow-out and signed overflow.
// Latency: accept at edge E, out_valid after edge E+NCH; one result per NCH+2 cycles with out_ready held high.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready, and in_valid is ignored meanwhile.
module serial_chunk_sub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf,
  output logic             busy
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  // Operands shift right by CHUNK each RUN cycle so the active chunk is always in the low bits.
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  // Result fills from the top; after NCH shifts every slice sits at its own bit position.
  logic [WIDTH-1:0] res_q, res_d;
  logic             brw_q, brw_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] chunk_slice;
  logic             chunk_brw;
  logic             chunk_msb_in;
  logic             chunk_ovf;
  logic [WIDTH-1:0] res_next;

  // Bit-level borrow chain over the current chunk; the borrow into its top bit feeds overflow on the last chunk.
  always_comb begin
    chunk_brw    = brw_q;
    chunk_msb_in = 1'b0;
    chunk_slice  = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) chunk_msb_in = chunk_brw;
      chunk_slice[i] = a_q[i] ^ b_q[i] ^ chunk_brw;
      chunk_brw      = (~a_q[i] & b_q[i]) | (~(a_q[i] ^ b_q[i]) & chunk_brw);
    end
    chunk_ovf = chunk_msb_in ^ chunk_brw;
    res_next  = (res_q >> CHUNK) | (WIDTH'(chunk_slice) << (WIDTH - CHUNK));
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          brw_d   = bin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d   = a_q >> CHUNK;
        b_d   = b_q >> CHUNK;
        res_d = res_next;
        brw_d = chunk_brw;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          d_d     = res_next;
          bout_d  = chunk_brw;
          ovf_d   = chunk_ovf;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = rst && (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign d         = d_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_chunk_sub.sv
// Bench for serial_chunk_sub: four instances (CHUNK = 1, 2, 4, 8 at WIDTH = 8) driven from one clock.
// Directed vector table, random operands against an arithmetic reference, plus backpressure, reset and throughput sequences.
// Each instance is exercised alone; the others sit idle with out_ready low.
module tb_serial_chunk_sub;

  localparam int NI = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid  [NI];
  logic       in_ready  [NI];
  logic [7:0] a         [NI];
  logic [7:0] b         [NI];
  logic       bin       [NI];
  logic       out_valid [NI];
  logic       out_ready [NI];
  logic [7:0] d         [NI];
  logic       bout      [NI];
  logic       ovf       [NI];
  logic       busy      [NI];

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  serial_chunk_sub #(.WIDTH(8), .CHUNK(1)) u_c1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .a(a[0]), .b(b[0]), .bin(bin[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .d(d[0]), .bout(bout[0]), .ovf(ovf[0]), .busy(busy[0]));
  serial_chunk_sub #(.WIDTH(8), .CHUNK(2)) u_c2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .a(a[1]), .b(b[1]), .bin(bin[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .d(d[1]), .bout(bout[1]), .ovf(ovf[1]), .busy(busy[1]));
  serial_chunk_sub #(.WIDTH(8), .CHUNK(4)) u_c4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .a(a[2]), .b(b[2]), .bin(bin[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .d(d[2]), .bout(bout[2]), .ovf(ovf[2]), .busy(busy[2]));
  serial_chunk_sub #(.WIDTH(8), .CHUNK(8)) u_c8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]), .a(a[3]), .b(b[3]), .bin(bin[3]),
    .out_valid(out_valid[3]), .out_ready(out_ready[3]), .d(d[3]), .bout(bout[3]), .ovf(ovf[3]), .busy(busy[3]));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bout;
    logic       ovf;
  } vec_t;

  function automatic int nch(input int idx);
    int ch;
    case (idx)
      0: ch = 1;
      1: ch = 2;
      2: ch = 4;
      default: ch = 8;
    endcase
    return 8 / ch;
  endfunction

  // Reference: plain integer arithmetic, unsigned for d/bout and signed range test for ovf.
  function automatic void model(input logic [7:0] ta, input logic [7:0] tb_, input logic tbin,
                                output logic [7:0] ed, output logic eb, output logic eo);
    int u;
    int s;
    u  = int'(ta) - int'(tb_) - int'(tbin);
    s  = int'($signed(ta)) - int'($signed(tb_)) - int'(tbin);
    ed = 8'(u);
    eb = (u < 0);
    eo = (s < -128) || (s > 127);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One full transaction on instance idx with latency, result and return-to-IDLE checks.
  task automatic run_op(input int idx, input logic [7:0] ta, input logic [7:0] tb_, input logic tbin,
                        input logic [7:0] ed, input logic eb, input logic eo, input string tag);
    int lat;
    @(negedge clk);
    chk({tag, " in_ready before accept"}, 32'(in_ready[idx]), 32'd1);
    a[idx] = ta; b[idx] = tb_; bin[idx] = tbin; in_valid[idx] = 1'b1;
    @(posedge clk); #1;
    in_valid[idx] = 1'b0;
    a[idx] = ~ta; b[idx] = 8'($urandom); bin[idx] = ~tbin;
    lat = 0;
    while (!out_valid[idx] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(nch(idx)));
    chk({tag, " d"},    32'(d[idx]),    32'(ed));
    chk({tag, " bout"}, 32'(bout[idx]), 32'(eb));
    chk({tag, " ovf"},  32'(ovf[idx]),  32'(eo));
    @(negedge clk);
    out_ready[idx] = 1'b1;
    @(posedge clk); #1;
    chk({tag, " out_valid drop"}, 32'(out_valid[idx]), 32'd0);
    chk({tag, " in_ready back"},  32'(in_ready[idx]),  32'd1);
    out_ready[idx] = 1'b0;
  endtask

  initial begin
    vec_t       tbl [7];
    logic [7:0] ra, rb, ed;
    logic       rbin, eb, eo;
    int         lat, seen, last, cyc;

    tbl[0] = '{a: 8'h05, b: 8'h03, bin: 1'b0, d: 8'h02, bout: 1'b0, ovf: 1'b0};
    tbl[1] = '{a: 8'h03, b: 8'h05, bin: 1'b0, d: 8'hFE, bout: 1'b1, ovf: 1'b0};
    tbl[2] = '{a: 8'h00, b: 8'h00, bin: 1'b1, d: 8'hFF, bout: 1'b1, ovf: 1'b0};
    tbl[3] = '{a: 8'h80, b: 8'h01, bin: 1'b0, d: 8'h7F, bout: 1'b0, ovf: 1'b1};
    tbl[4] = '{a: 8'h7F, b: 8'hFF, bin: 1'b0, d: 8'h80, bout: 1'b1, ovf: 1'b1};
    tbl[5] = '{a: 8'h10, b: 8'h01, bin: 1'b0, d: 8'h0F, bout: 1'b0, ovf: 1'b0};
    tbl[6] = '{a: 8'hA0, b: 8'h0F, bin: 1'b0, d: 8'h91, bout: 1'b0, ovf: 1'b0};

    rst = 1'b0;
    for (int i = 0; i < NI; i++) begin
      in_valid[i] = 1'b0; a[i] = '0; b[i] = '0; bin[i] = 1'b0; out_ready[i] = 1'b0;
    end

    // Reset state of every instance.
    #12;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("reset d[%0d]", i),         32'(d[i]),         32'd0);
      chk($sformatf("reset bout[%0d]", i),      32'(bout[i]),      32'd0);
      chk($sformatf("reset ovf[%0d]", i),       32'(ovf[i]),       32'd0);
      chk($sformatf("reset out_valid[%0d]", i), 32'(out_valid[i]), 32'd0);
      chk($sformatf("reset busy[%0d]", i),      32'(busy[i]),      32'd0);
      chk($sformatf("reset in_ready[%0d]", i),  32'(in_ready[i]),  32'd0);
    end
    @(negedge clk);
    rst = 1'b1;

    // Directed vectors on every instance.
    for (int i = 0; i < NI; i++)
      for (int v = 0; v < 7; v++)
        run_op(i, tbl[v].a, tbl[v].b, tbl[v].bin, tbl[v].d, tbl[v].bout, tbl[v].ovf,
               $sformatf("vec%0d inst%0d", v, i));

    // Random operands against the reference model.
    for (int i = 0; i < NI; i++)
      for (int n = 0; n < 60; n++) begin
        ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
        model(ra, rb, rbin, ed, eb, eo);
        run_op(i, ra, rb, rbin, ed, eb, eo, $sformatf("rand%0d inst%0d %h-%h-%0d", n, i, ra, rb, rbin));
      end

    // Backpressure: hold DONE for 5 cycles, poke in_valid, then release.
    @(negedge clk);
    a[0] = 8'h80; b[0] = 8'h01; bin[0] = 1'b0; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    lat = 0;
    while (!out_valid[0] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp latency", 32'(lat), 32'd8);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 2) begin
        a[0] = 8'h00; b[0] = 8'h55; bin[0] = 1'b1; in_valid[0] = 1'b1;
      end else begin
        in_valid[0] = 1'b0;
      end
      @(posedge clk); #1;
      chk($sformatf("bp out_valid c%0d", c), 32'(out_valid[0]), 32'd1);
      chk($sformatf("bp in_ready c%0d", c),  32'(in_ready[0]),  32'd0);
      chk($sformatf("bp d c%0d", c),         32'(d[0]),         32'h7F);
      chk($sformatf("bp bout c%0d", c),      32'(bout[0]),      32'd0);
      chk($sformatf("bp ovf c%0d", c),       32'(ovf[0]),       32'd1);
    end
    @(negedge clk);
    in_valid[0] = 1'b0; out_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp release out_valid", 32'(out_valid[0]), 32'd0);
    chk("bp release in_ready",  32'(in_ready[0]),  32'd1);
    chk("bp release busy",      32'(busy[0]),      32'd0);
    out_ready[0] = 1'b0;

    // Asynchronous reset three cycles into RUN, with non-zero outputs beforehand.
    run_op(0, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, "pre-reset");
    @(negedge clk);
    a[0] = 8'hFF; b[0] = 8'h00; bin[0] = 1'b1; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async rst d",         32'(d[0]),         32'd0);
    chk("async rst bout",      32'(bout[0]),      32'd0);
    chk("async rst ovf",       32'(ovf[0]),       32'd0);
    chk("async rst out_valid", 32'(out_valid[0]), 32'd0);
    chk("async rst busy",      32'(busy[0]),      32'd0);
    chk("async rst in_ready",  32'(in_ready[0]),  32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_op(0, 8'hA0, 8'h0F, 1'b0, 8'h91, 1'b0, 1'b0, "post-reset");

    // Back-to-back throughput with in_valid and out_ready held high.
    for (int i = 0; i < NI; i++) begin
      @(negedge clk);
      a[i] = 8'h10; b[i] = 8'h01; bin[i] = 1'b0; in_valid[i] = 1'b1; out_ready[i] = 1'b1;
      seen = 0; last = -1; cyc = 0;
      while (seen < 3 && cyc < 100) begin
        @(posedge clk); #1;
        cyc++;
        if (out_valid[i]) begin
          chk($sformatf("b2b d inst%0d", i), 32'(d[i]), 32'h0F);
          if (last >= 0) chk($sformatf("b2b period inst%0d", i), 32'(cyc - last), 32'(nch(i) + 2));
          last = cyc;
          seen++;
        end
      end
      chk($sformatf("b2b results seen inst%0d", i), 32'(seen), 32'd3);
      @(negedge clk);
      in_valid[i] = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      out_ready[i] = 1'b0;
      chk($sformatf("b2b idle inst%0d", i), 32'(busy[i]), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
